// File: rtl/async_fifo_pkg.sv
// Shared definitions for the Gray-pointer FIFO slice.
// Holds the default geometry and the binary-to-Gray helper used when pointers are registered.
package async_fifo_pkg;

   localparam int unsigned DEFAULT_WIDTH  = 8;
   localparam int unsigned DEFAULT_DEPTH  = 4;
   localparam int unsigned DEFAULT_STAGES = 2;

   // Callers cast the result down to their pointer width.
   function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/async_fifo_if.sv
// Handshake bundle between a producer/consumer (master) and the FIFO (slave).
//   write_enable, write_data : push request and word from the producer
//   write_full               : back-pressure towards the producer
//   read_enable              : pop request from the consumer
//   read_data, read_empty    : head word (first-word-fall-through) and its validity
interface async_fifo_if #(
   parameter int unsigned WIDTH = 8
);
   logic             write_enable;
   logic [WIDTH-1:0] write_data;
   logic             write_full;
   logic             read_enable;
   logic [WIDTH-1:0] read_data;
   logic             read_empty;

   modport master (
      output write_enable, write_data, read_enable,
      input  write_full, read_data, read_empty
   );

   modport slave (
      input  write_enable, write_data, read_enable,
      output write_full, read_data, read_empty
   );
endinterface

// File: rtl/vector_synchronizer.sv
// Plain flop chain used to carry a Gray-coded pointer to the opposite side of the FIFO.
//   clock, reset : rising-edge clock, asynchronous active-high reset (chain clears to 0)
//   data_i       : vector entering the chain
//   data_o       : vector after STAGES flops
module vector_synchronizer #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= data_i;
         for (int unsigned i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign data_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo.sv
// Gray-pointer FIFO with a first-word-fall-through read port, run from a single clock but
// keeping the pointer-crossing architecture so flag latency matches the dual-clock variant.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : write_enable/write_data/write_full on the push side,
//                  read_enable/read_data/read_empty on the pop side
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter int unsigned STAGES = DEFAULT_STAGES
) (
   input  logic         clock,
   input  logic         reset,
   async_fifo_if.slave  bus
);

   localparam int unsigned ADDR = $clog2(DEPTH);
   localparam int unsigned PTR  = ADDR + 1;

   // Top two Gray bits inverted marks "one full lap ahead".
   localparam logic [PTR-1:0] FULL_MASK = PTR'(3) << (PTR - 2);

   logic [PTR-1:0]   wbin_q, wbin_d, wgray_q;
   logic [PTR-1:0]   rbin_q, rbin_d, rgray_q;
   logic [PTR-1:0]   wgray_sync, rgray_sync;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             write_fire, read_fire;

   assign write_fire = bus.write_enable & ~bus.write_full;
   assign read_fire  = bus.read_enable & ~bus.read_empty;

   always_comb begin
      wbin_d = wbin_q + PTR'(write_fire);
      rbin_d = rbin_q + PTR'(read_fire);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         rbin_q  <= '0;
         rgray_q <= '0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= PTR'(bin_to_gray(32'(wbin_d)));
         rbin_q  <= rbin_d;
         rgray_q <= PTR'(bin_to_gray(32'(rbin_d)));
      end
   end

   // Storage is intentionally not reset; contents are only observable while non-empty.
   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (write_fire && (wbin_q[ADDR-1:0] == ADDR'(i))) begin
            mem_q[i] <= bus.write_data;
         end
      end
   end

   vector_synchronizer #(
      .WIDTH  (PTR),
      .STAGES (STAGES)
   ) u_wgray_sync (
      .clock  (clock),
      .reset  (reset),
      .data_i (wgray_q),
      .data_o (wgray_sync)
   );

   vector_synchronizer #(
      .WIDTH  (PTR),
      .STAGES (STAGES)
   ) u_rgray_sync (
      .clock  (clock),
      .reset  (reset),
      .data_i (rgray_q),
      .data_o (rgray_sync)
   );

   assign bus.read_data  = mem_q[rbin_q[ADDR-1:0]];
   assign bus.read_empty = (rgray_q == wgray_sync);
   assign bus.write_full = (wgray_q == (rgray_sync ^ FULL_MASK));

endmodule

// File: tb/tb_async_fifo.sv
// Randomised self-checking bench for async_fifo.
// The reference model tracks accepted pushes/pops as plain counts plus a data queue; each flag
// sees the opposite side's count as it stood STAGES edges earlier.
module tb_async_fifo;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned STAGES = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;

   async_fifo_if #(.WIDTH(WIDTH)) bus ();

   async_fifo #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .STAGES (STAGES)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // Model state
   logic [WIDTH-1:0] model_q [$];
   int unsigned      wc, rc;
   int unsigned      wc_hist [$];
   int unsigned      rc_hist [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      model_q.delete();
      wc = 0;
      rc = 0;
      wc_hist.delete();
      rc_hist.delete();
      for (int i = 0; i <= int'(STAGES); i++) begin
         wc_hist.push_back(0);
         rc_hist.push_back(0);
      end
   endtask

   // Called at a falling edge: check outputs, drive inputs, advance one rising edge.
   task automatic step(input logic we, input logic re, input logic [WIDTH-1:0] wd);
      logic exp_empty, exp_full;
      exp_empty = (rc == wc_hist[0]);
      exp_full  = ((wc - rc_hist[0]) == DEPTH);
      check_eq("read_empty", 32'(bus.read_empty), 32'(exp_empty));
      check_eq("write_full", 32'(bus.write_full), 32'(exp_full));
      if (!exp_empty) begin
         check_eq("read_data", 32'(bus.read_data), 32'(model_q[0]));
      end
      bus.write_enable = we;
      bus.write_data   = wd;
      bus.read_enable  = re;
      @(posedge clock);
      if (we && !exp_full) begin
         model_q.push_back(wd);
         wc++;
      end
      if (re && !exp_empty) begin
         void'(model_q.pop_front());
         rc++;
      end
      wc_hist.push_back(wc);
      void'(wc_hist.pop_front());
      rc_hist.push_back(rc);
      void'(rc_hist.pop_front());
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
   endtask

   int unsigned base_rc;
   int unsigned base_wc;
   int          budget;

   initial begin
      bus.write_enable = 1'b0;
      bus.write_data   = '0;
      bus.read_enable  = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_eq("rst_empty", 32'(bus.read_empty), 32'd1);
      check_eq("rst_full", 32'(bus.write_full), 32'd0);
      reset = 1'b0;

      // Fill, then a rejected 5th write
      for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 1'b0, WIDTH'($urandom));
      idle(STAGES + 1);
      check_eq("fill_full", 32'(bus.write_full), 32'd1);
      step(1'b1, 1'b0, 8'hA5);
      idle(1);

      // Drain, then a rejected read while empty
      for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b1, '0);
      check_eq("drain_empty", 32'(bus.read_empty), 32'd1);
      idle(STAGES + 1);
      step(1'b0, 1'b1, '0);
      idle(STAGES + 1);
      check_eq("underflow_empty", 32'(bus.read_empty), 32'd1);

      // Max throughput: 100 words, push and pop every cycle
      base_rc = rc;
      base_wc = wc;
      budget  = 2000;
      while ((rc - base_rc) < 100 && budget > 0) begin
         step((wc - base_wc) < 100, 1'b1, WIDTH'($urandom));
         budget--;
      end
      check_eq("tput_done", 32'(rc - base_rc), 32'd100);
      idle(STAGES + 1);
      check_eq("tput_end_empty", 32'(bus.read_empty), 32'd1);
      check_eq("tput_end_full", 32'(bus.write_full), 32'd0);

      // Random 50/50 traffic, 100 words with many pointer wraps
      base_rc = rc;
      base_wc = wc;
      budget  = 5000;
      while ((rc - base_rc) < 100 && budget > 0) begin
         step(($urandom_range(1, 0) == 1) && ((wc - base_wc) < 100),
              $urandom_range(1, 0) == 1, WIDTH'($urandom));
         budget--;
      end
      check_eq("rand_done", 32'(rc - base_rc), 32'd100);
      idle(STAGES + 1);
      check_eq("rand_end_empty", 32'(bus.read_empty), 32'd1);
      check_eq("rand_end_full", 32'(bus.write_full), 32'd0);

      // Reset mid-operation discards contents at once
      for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 1'b0, WIDTH'($urandom));
      idle(STAGES);
      reset = 1'b1;
      #1;
      check_eq("midrst_empty", 32'(bus.read_empty), 32'd1);
      check_eq("midrst_full", 32'(bus.write_full), 32'd0);
      model_reset();
      bus.write_enable = 1'b0;
      bus.read_enable  = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      idle(STAGES + 1);
      step(1'b1, 1'b0, 8'h3C);
      idle(STAGES + 1);
      step(1'b0, 1'b1, '0);
      idle(STAGES + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case something above never returns.
   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
